// File: rtl/mm_addr_gen.sv
// Loop-nest address sequencer for the A*B + C -> D job: issues banked operand addresses and a
// write-back-aligned D address. Define MM_ADDR_GEN_BANK_CHECK_EN to build the sticky bank-conflict flag.
module mm_addr_gen #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 8,
  parameter int WB_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic [ADDR_WIDTH+1:0] cfg_a_base,
  input  logic [ADDR_WIDTH+1:0] cfg_b_base,
  input  logic [ADDR_WIDTH+1:0] cfg_c_base,
  input  logic [ADDR_WIDTH+1:0] cfg_d_base,
  input  logic [ADDR_WIDTH+1:0] cfg_a_stride,
  input  logic [ADDR_WIDTH+1:0] cfg_b_stride,
  input  logic [ADDR_WIDTH+1:0] cfg_c_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [CNT_WIDTH-1:0]  cfg_cols,
  input  logic [CNT_WIDTH-1:0]  cfg_inner,
  input  logic                  cfg_bia,
  output logic                  busy,
  output logic                  done,
  output logic                  issue_valid,
  output logic                  k_first,
  output logic                  k_last,
  output logic [ADDR_WIDTH+1:0] A_addr,
  output logic [ADDR_WIDTH+1:0] B_addr,
  output logic [ADDR_WIDTH+1:0] C_addr,
  output logic [ADDR_WIDTH+1:0] D_addr,
  output logic                  C_bia,
  output logic                  D_bia,
  output logic                  d_we,
  output logic                  bank_err
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one operand triple per unstalled cycle, k innermost
  // DRAIN | counting down until the last result leaves the write-back pipe
  // DONE  | last cycle of the job; done pulse and busy fall are registered on exit
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
  localparam logic [AW-1:0]        ADDR_ONE   = 1;
  localparam logic [3:0]           DRAIN_LOAD = 4'(WB_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic issue_valid_q, issue_valid_d, k_first_q, k_first_d, k_last_q, k_last_d;
  logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [CNT_WIDTH-1:0] i_rem_q, i_rem_d, j_rem_q, j_rem_d, k_rem_q, k_rem_d;
  logic [CNT_WIDTH-1:0] cols_q, cols_d, inner_q, inner_d;
  logic [3:0] drain_q, drain_d;
  logic [AW-1:0] a_row_q, a_row_d, a_cur_q, a_cur_d;
  logic [AW-1:0] b_col_q, b_col_d, b_cur_q, b_cur_d;
  logic [AW-1:0] c_row_q, c_row_d, c_cur_q, c_cur_d;
  logic [AW-1:0] a_stride_q, a_stride_d, b_stride_q, b_stride_d, c_stride_q, c_stride_d;
  logic [AW-1:0] b_base_q, b_base_d, d_off_q, d_off_d;
  logic bia_q, bia_d;
  logic [WB_LAT-1:0] we_pipe_q;
  logic [AW-1:0] d_pipe_q [WB_LAT];
`ifdef MM_ADDR_GEN_BANK_CHECK_EN
  logic bank_err_q, bank_err_d;
`endif

  always_comb begin
    state_d = state_q;  busy_d = busy_q;  done_d = done_q;
    issue_valid_d = issue_valid_q;  k_first_d = k_first_q;  k_last_d = k_last_q;
    a_addr_d = a_addr_q;  b_addr_d = b_addr_q;  c_addr_d = c_addr_q;
    i_rem_d = i_rem_q;  j_rem_d = j_rem_q;  k_rem_d = k_rem_q;
    cols_d = cols_q;  inner_d = inner_q;  drain_d = drain_q;
    a_row_d = a_row_q;  a_cur_d = a_cur_q;  b_col_d = b_col_q;  b_cur_d = b_cur_q;
    c_row_d = c_row_q;  c_cur_d = c_cur_q;
    a_stride_d = a_stride_q;  b_stride_d = b_stride_q;  c_stride_d = c_stride_q;
    b_base_d = b_base_q;  d_off_d = d_off_q;  bia_d = bia_q;
`ifdef MM_ADDR_GEN_BANK_CHECK_EN
    bank_err_d = bank_err_q;
`endif
    if (!stall) begin
      issue_valid_d = 1'b0;  k_first_d = 1'b0;  k_last_d = 1'b0;  done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: if (start) begin
          busy_d = 1'b1;  drain_d = '0;
          i_rem_d = cfg_rows - CNT_ONE;  j_rem_d = cfg_cols - CNT_ONE;  k_rem_d = cfg_inner - CNT_ONE;
          cols_d = cfg_cols;  inner_d = cfg_inner;
          a_row_d = cfg_a_base;  a_cur_d = cfg_a_base;
          b_col_d = cfg_b_base;  b_cur_d = cfg_b_base;  b_base_d = cfg_b_base;
          c_row_d = cfg_c_base;  c_cur_d = cfg_c_base;
          a_stride_d = cfg_a_stride;  b_stride_d = cfg_b_stride;  c_stride_d = cfg_c_stride;
          d_off_d = cfg_d_base - cfg_c_base;
          bia_d = cfg_bia;
`ifdef MM_ADDR_GEN_BANK_CHECK_EN
          bank_err_d = 1'b0;
`endif
          // An empty job still spends one DRAIN cycle so done lands on the same edge as always.
          if (cfg_rows == '0 || cfg_cols == '0 || cfg_inner == '0) state_d = ST_DRAIN;
          else state_d = ST_RUN;
        end
        ST_RUN: begin
          issue_valid_d = 1'b1;
          a_addr_d = a_cur_q;  b_addr_d = b_cur_q;  c_addr_d = c_cur_q;
          k_first_d = (k_rem_q == inner_q - CNT_ONE);
          k_last_d  = (k_rem_q == '0);
`ifdef MM_ADDR_GEN_BANK_CHECK_EN
          if (a_cur_q[AW-1:AW-2] == b_cur_q[AW-1:AW-2] ||
              c_cur_q[AW-1:AW-2] == a_cur_q[AW-1:AW-2] ||
              c_cur_q[AW-1:AW-2] == b_cur_q[AW-1:AW-2]) bank_err_d = 1'b1;
`endif
          if (k_rem_q != '0) begin
            k_rem_d = k_rem_q - CNT_ONE;
            a_cur_d = a_cur_q + ADDR_ONE;
            b_cur_d = b_cur_q + ADDR_ONE;
          end else begin
            k_rem_d = inner_q - CNT_ONE;
            if (j_rem_q != '0) begin
              j_rem_d = j_rem_q - CNT_ONE;
              b_col_d = b_col_q + b_stride_q;  b_cur_d = b_col_q + b_stride_q;
              a_cur_d = a_row_q;
              c_cur_d = c_cur_q + ADDR_ONE;
            end else begin
              j_rem_d = cols_q - CNT_ONE;
              b_col_d = b_base_q;  b_cur_d = b_base_q;
              if (i_rem_q != '0) begin
                i_rem_d = i_rem_q - CNT_ONE;
                a_row_d = a_row_q + a_stride_q;  a_cur_d = a_row_q + a_stride_q;
                c_row_d = c_row_q + c_stride_q;  c_cur_d = c_row_q + c_stride_q;
              end else begin
                state_d = ST_DRAIN;
                drain_d = DRAIN_LOAD;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_d = ST_DONE;
          else drain_d = drain_q - 4'd1;
        end
        ST_DONE: begin
          state_d = ST_IDLE;  done_d = 1'b1;  busy_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;
      issue_valid_q <= 1'b0;  k_first_q <= 1'b0;  k_last_q <= 1'b0;
      a_addr_q <= '0;  b_addr_q <= '0;  c_addr_q <= '0;
      i_rem_q <= '0;  j_rem_q <= '0;  k_rem_q <= '0;  cols_q <= '0;  inner_q <= '0;  drain_q <= '0;
      a_row_q <= '0;  a_cur_q <= '0;  b_col_q <= '0;  b_cur_q <= '0;  c_row_q <= '0;  c_cur_q <= '0;
      a_stride_q <= '0;  b_stride_q <= '0;  c_stride_q <= '0;  b_base_q <= '0;  d_off_q <= '0;
      bia_q <= 1'b0;
    end else begin
      state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;
      issue_valid_q <= issue_valid_d;  k_first_q <= k_first_d;  k_last_q <= k_last_d;
      a_addr_q <= a_addr_d;  b_addr_q <= b_addr_d;  c_addr_q <= c_addr_d;
      i_rem_q <= i_rem_d;  j_rem_q <= j_rem_d;  k_rem_q <= k_rem_d;  cols_q <= cols_d;  inner_q <= inner_d;
      drain_q <= drain_d;
      a_row_q <= a_row_d;  a_cur_q <= a_cur_d;  b_col_q <= b_col_d;  b_cur_q <= b_cur_d;
      c_row_q <= c_row_d;  c_cur_q <= c_cur_d;
      a_stride_q <= a_stride_d;  b_stride_q <= b_stride_d;  c_stride_q <= c_stride_d;
      b_base_q <= b_base_d;  d_off_q <= d_off_d;  bia_q <= bia_d;
    end
  end

  // Write-back pipe is fed from the registered issue, so a result emerges WB_LAT edges after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_pipe_q <= '0;
      for (int s = 0; s < WB_LAT; s++) d_pipe_q[s] <= '0;
    end else if (!stall) begin
      we_pipe_q[0] <= issue_valid_q & k_last_q;
      d_pipe_q[0]  <= c_addr_q + d_off_q;
      for (int s = 1; s < WB_LAT; s++) begin
        we_pipe_q[s] <= we_pipe_q[s-1];
        d_pipe_q[s]  <= d_pipe_q[s-1];
      end
    end
  end

`ifdef MM_ADDR_GEN_BANK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_err_q <= 1'b0;
    else        bank_err_q <= bank_err_d;
  end
  assign bank_err = bank_err_q;
`else
  assign bank_err = 1'b0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = issue_valid_q;
  assign k_first     = k_first_q;
  assign k_last      = k_last_q;
  assign A_addr      = a_addr_q;
  assign B_addr      = b_addr_q;
  assign C_addr      = c_addr_q;
  assign D_addr      = d_pipe_q[WB_LAT-1];
  assign d_we        = we_pipe_q[WB_LAT-1];
  assign C_bia       = bia_q;
  assign D_bia       = bia_q;
endmodule

// File: tb/tb_mm_addr_gen.sv
// Self-checking bench for mm_addr_gen: directed and random jobs against a nested-loop reference model.
module tb_mm_addr_gen;
  localparam int ADDR_WIDTH = 12;
  localparam int CNT_WIDTH  = 8;
  localparam int WB_LAT     = 3;
  localparam int AW         = ADDR_WIDTH + 2;

  logic clk = 1'b0;
  logic rst_n, start, stall;
  logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_c_base, cfg_d_base;
  logic [AW-1:0] cfg_a_stride, cfg_b_stride, cfg_c_stride;
  logic [CNT_WIDTH-1:0] cfg_rows, cfg_cols, cfg_inner;
  logic cfg_bia;
  logic busy, done, issue_valid, k_first, k_last, C_bia, D_bia, d_we, bank_err;
  logic [AW-1:0] A_addr, B_addr, C_addr, D_addr;

  int tests_run = 0;
  int tests_failed = 0;

  mm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base), .cfg_d_base(cfg_d_base),
    .cfg_a_stride(cfg_a_stride), .cfg_b_stride(cfg_b_stride), .cfg_c_stride(cfg_c_stride),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_inner(cfg_inner), .cfg_bia(cfg_bia),
    .busy(busy), .done(done), .issue_valid(issue_valid), .k_first(k_first), .k_last(k_last),
    .A_addr(A_addr), .B_addr(B_addr), .C_addr(C_addr), .D_addr(D_addr),
    .C_bia(C_bia), .D_bia(D_bia), .d_we(d_we), .bank_err(bank_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    cfg_a_base = AW'($urandom);  cfg_b_base = AW'($urandom);
    cfg_c_base = AW'($urandom);  cfg_d_base = AW'($urandom);
    cfg_a_stride = AW'($urandom);  cfg_b_stride = AW'($urandom);  cfg_c_stride = AW'($urandom);
    cfg_rows = CNT_WIDTH'($urandom_range(0, 5));
    cfg_cols = CNT_WIDTH'($urandom_range(0, 5));
    cfg_inner = CNT_WIDTH'($urandom_range(0, 5));
    cfg_bia = 1'($urandom);
  endtask

  // Runs one job from start acceptance (t=0) until one edge past done; t counts unstalled edges.
  task automatic run_job(input int rows, input int cols, input int inner,
                         input logic [AW-1:0] ab, input logic [AW-1:0] as_,
                         input logic [AW-1:0] bb, input logic [AW-1:0] bs,
                         input logic [AW-1:0] cb, input logic [AW-1:0] cs,
                         input logic [AW-1:0] db, input bit bia,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit disturb);
    logic [AW-1:0] ea[$], eb[$], ec[$], wd[$];
    bit ekf[$], ekl[$], econf[$];
    int wt[$];
    int unsigned mask, a_v, b_v, c_v, d_v;
    int n_iss, done_t, t, cyc, held, idx;
    bit st, first, exp_iv, exp_kf, exp_kl, exp_we, exp_err;
    logic [AW-1:0] exp_d;
    mask = (32'd1 << AW) - 32'd1;
    idx = 0;
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < cols; j++)
        for (int k = 0; k < inner; k++) begin
          a_v = (int'(ab) + i * int'(as_) + k) & mask;
          b_v = (int'(bb) + j * int'(bs) + k) & mask;
          c_v = (int'(cb) + i * int'(cs) + j) & mask;
          ea.push_back(AW'(a_v));  eb.push_back(AW'(b_v));  ec.push_back(AW'(c_v));
          ekf.push_back(k == 0);  ekl.push_back(k == inner - 1);
          econf.push_back(((a_v >> ADDR_WIDTH) == (b_v >> ADDR_WIDTH)) ||
                          ((c_v >> ADDR_WIDTH) == (a_v >> ADDR_WIDTH)) ||
                          ((c_v >> ADDR_WIDTH) == (b_v >> ADDR_WIDTH)));
          if (k == inner - 1) begin
            d_v = (int'(db) + i * int'(cs) + j) & mask;
            wt.push_back(idx + 1 + WB_LAT);
            wd.push_back(AW'(d_v));
          end
          idx++;
        end
    n_iss = rows * cols * inner;
    done_t = (n_iss == 0) ? 2 : n_iss + WB_LAT + 1;

    first = 1'b1;  t = -1;  cyc = 0;  held = 0;
    while (t <= done_t && cyc < 1000) begin
      @(negedge clk);
      if (first) begin
        cfg_a_base = ab;  cfg_a_stride = as_;  cfg_b_base = bb;  cfg_b_stride = bs;
        cfg_c_base = cb;  cfg_c_stride = cs;  cfg_d_base = db;  cfg_bia = bia;
        cfg_rows = CNT_WIDTH'(rows);  cfg_cols = CNT_WIDTH'(cols);  cfg_inner = CNT_WIDTH'(inner);
        start = 1'b1;  st = 1'b0;
      end else begin
        start = 1'b0;
        if (disturb) begin
          scramble_cfg();
          start = (t + 1 < done_t) && ($urandom_range(0, 4) == 0);
        end
        st = 1'b0;
        if (stall_len > 0 && t == stall_at && held < stall_len) begin
          st = 1'b1;  held++;
        end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) st = 1'b1;
      end
      stall = st;
      @(posedge clk); #1;
      if (!st) t++;
      first = 1'b0;  cyc++;

      exp_iv = (t >= 1 && t <= n_iss);
      exp_kf = 1'b0;  exp_kl = 1'b0;
      check("issue_valid", 32'(issue_valid), 32'(exp_iv));
      if (exp_iv) begin
        check("A_addr", 32'(A_addr), 32'(ea[t-1]));
        check("B_addr", 32'(B_addr), 32'(eb[t-1]));
        check("C_addr", 32'(C_addr), 32'(ec[t-1]));
        exp_kf = ekf[t-1];  exp_kl = ekl[t-1];
      end
      check("k_first", 32'(k_first), 32'(exp_kf));
      check("k_last", 32'(k_last), 32'(exp_kl));
      exp_we = 1'b0;  exp_d = '0;
      foreach (wt[w]) if (wt[w] == t) begin exp_we = 1'b1;  exp_d = wd[w]; end
      check("d_we", 32'(d_we), 32'(exp_we));
      if (exp_we) check("D_addr", 32'(D_addr), 32'(exp_d));
      check("done", 32'(done), 32'(t == done_t));
      check("busy", 32'(busy), 32'(t < done_t));
      check("C_bia", 32'(C_bia), 32'(bia));
      check("D_bia", 32'(D_bia), 32'(bia));
      exp_err = 1'b0;
`ifdef MM_ADDR_GEN_BANK_CHECK_EN
      for (int m = 0; m < t && m < n_iss; m++) if (econf[m]) exp_err = 1'b1;
`endif
      check("bank_err", 32'(bank_err), 32'(exp_err));
    end
    if (t <= done_t) check("job_timeout", 32'(t), 32'(done_t + 1));
    start = 1'b0;  stall = 1'b0;
  endtask

  task automatic reset_abort_test();
    @(negedge clk);
    cfg_a_base = 14'h0100;  cfg_a_stride = 14'd3;  cfg_b_base = 14'h1000;  cfg_b_stride = 14'd3;
    cfg_c_base = 14'h2000;  cfg_c_stride = 14'd2;  cfg_d_base = 14'h3000;  cfg_bia = 1'b1;
    cfg_rows = 8'd2;  cfg_cols = 8'd2;  cfg_inner = 8'd3;  start = 1'b1;  stall = 1'b0;
    @(negedge clk);  start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_valid", 32'(issue_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(issue_valid), 32'd0);
    check("abort_A", 32'(A_addr), 32'd0);
    check("abort_C", 32'(C_addr), 32'd0);
    check("abort_kfl", 32'({k_first, k_last}), 32'd0);
    check("abort_dwe", 32'(d_we), 32'd0);
    check("abort_bia", 32'({C_bia, D_bia}), 32'd0);
    @(negedge clk);  rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'({done, busy, issue_valid, d_we}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;  start = 1'b0;  stall = 1'b0;
    cfg_a_base = '0;  cfg_b_base = '0;  cfg_c_base = '0;  cfg_d_base = '0;
    cfg_a_stride = '0;  cfg_b_stride = '0;  cfg_c_stride = '0;
    cfg_rows = '0;  cfg_cols = '0;  cfg_inner = '0;  cfg_bia = 1'b0;
    #12;
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_issue", 32'({issue_valid, k_first, k_last}), 32'd0);
    check("rst_addr", 32'(A_addr | B_addr | C_addr | D_addr), 32'd0);
    check("rst_misc", 32'({d_we, C_bia, D_bia, bank_err}), 32'd0);
    @(negedge clk);  rst_n = 1'b1;

    // Reference job: 12 issues, D writes 0x3000..0x3003
    run_job(2, 2, 3, 14'h0000, 14'd3, 14'h1000, 14'd3, 14'h2000, 14'd2, 14'h3000, 1'b0, 0, 0, 0, 1'b0);
    // Empty jobs, one per zero dimension
    run_job(2, 2, 0, 14'h0123, 14'd5, 14'h1000, 14'd7, 14'h2000, 14'd2, 14'h3000, 1'b1, 0, 0, 0, 1'b1);
    run_job(0, 3, 2, 14'h0123, 14'd5, 14'h1000, 14'd7, 14'h2000, 14'd2, 14'h3000, 1'b0, 0, 0, 0, 1'b0);
    run_job(3, 0, 1, 14'h0123, 14'd5, 14'h1000, 14'd7, 14'h2000, 14'd2, 14'h3000, 1'b1, 0, 0, 0, 1'b0);
    // Address wrap at the top of the bus space
    run_job(1, 1, 4, 14'h3FFE, 14'd1, 14'h1000, 14'd1, 14'h2000, 14'd1, 14'h3000, 1'b1, 0, 0, 0, 1'b1);
    // Four-cycle stall in the middle of RUN
    run_job(2, 2, 3, 14'h0000, 14'd3, 14'h1000, 14'd3, 14'h2000, 14'd2, 14'h3000, 1'b0, 0, 5, 4, 1'b0);
    // A and B in the same bank, then a clean job that must clear the flag
    run_job(1, 2, 2, 14'h0000, 14'd4, 14'h0010, 14'd4, 14'h2000, 14'd1, 14'h3000, 1'b0, 0, 0, 0, 1'b1);
    run_job(1, 1, 2, 14'h0000, 14'd4, 14'h1000, 14'd4, 14'h2000, 14'd1, 14'h3000, 1'b0, 0, 0, 0, 1'b0);

    for (int n = 0; n < 20; n++)
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4),
              AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
              AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
              20, 0, 0, 1'b1);

    reset_abort_test();
    run_job(2, 3, 2, 14'h0040, 14'd9, 14'h1100, 14'd2, 14'h2200, 14'd5, 14'h3300, 1'b1, 10, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
